// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake game: IDLE/RUN/PAUSE/OVER flow, level-scaled move tick,
// and qualification of raw collision pulses into one-cycle score-tracker commands.
module snake_game_ctrl #(
  parameter int TICK_INIT        = 50,
  parameter int TICK_MIN         = 10,
  parameter int TICK_STEP        = 5,
  parameter int APPLES_PER_LEVEL = 4,
  parameter int MAX_SCORE        = 99,
  parameter int LEVEL_MAX        = 15
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  output logic       moveTick_o,
  output logic       goodColl_o,
  output logic       badColl_o,
  output logic       scoreClr_o,
  output logic       isGameComplete_o,
  output logic       isWin_o,
  output logic [1:0] state_o,
  output logic [3:0] level_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

  localparam int CW = $clog2(TICK_INIT + 1);

  state_t        state, state_n;
  logic [3:0]    level, level_n;
  logic [6:0]    eaten, eaten_n;
  logic [6:0]    apl_cnt, apl_cnt_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          start_q, pause_q, good_q, bad_q;
  logic          start_e, pause_e, good_e, bad_e;
  logic          tick_n, good_n, bad_n, clr_n, win_n;

  // Period evaluated in signed int so a large level never wraps below the floor.
  function automatic logic [CW-1:0] calc_period(input logic [3:0] lvl);
    int p;
    p = TICK_INIT - int'(lvl) * TICK_STEP;
    if (p < TICK_MIN) p = TICK_MIN;
    return CW'(p);
  endfunction

  assign start_e = start_i    & ~start_q;
  assign pause_e = pause_i    & ~pause_q;
  assign good_e  = goodColl_i & ~good_q;
  assign bad_e   = badColl_i  & ~bad_q;

  always_comb begin
    state_n   = state;
    level_n   = level;
    eaten_n   = eaten;
    apl_cnt_n = apl_cnt;
    cnt_n     = cnt;
    tick_n    = 1'b0;
    good_n    = 1'b0;
    bad_n     = 1'b0;
    clr_n     = 1'b0;
    win_n     = isWin_o;
    case (state)
      IDLE, OVER: begin
        if (start_e) begin
          state_n   = RUN;
          clr_n     = 1'b1;
          level_n   = 4'd0;
          eaten_n   = 7'd0;
          apl_cnt_n = 7'd0;
          cnt_n     = CW'(TICK_INIT);
          win_n     = 1'b0;
        end
      end
      RUN: begin
        if (bad_e) begin
          bad_n   = 1'b1;
          state_n = OVER;
          win_n   = 1'b0;
        end else begin
          if (good_e) begin
            good_n  = 1'b1;
            eaten_n = eaten + 7'd1;
            if (eaten_n == 7'(MAX_SCORE)) begin
              state_n = OVER;
              win_n   = 1'b1;
            end else if (apl_cnt == 7'(APPLES_PER_LEVEL - 1)) begin
              apl_cnt_n = 7'd0;
              if (level != 4'(LEVEL_MAX)) level_n = level + 4'd1;
            end else begin
              apl_cnt_n = apl_cnt + 7'd1;
            end
          end
          if (pause_e && state_n != OVER) state_n = PAUSE;
        end
        // Entering PAUSE freezes the counter at the value seen on the pause edge.
        if (state_n != PAUSE) begin
          if (cnt == CW'(1)) begin
            tick_n = 1'b1;
            cnt_n  = calc_period(level);
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      PAUSE: begin
        if (pause_e || start_e) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state            <= IDLE;
      level            <= 4'd0;
      eaten            <= 7'd0;
      apl_cnt          <= 7'd0;
      cnt              <= CW'(TICK_INIT);
      start_q          <= 1'b0;
      pause_q          <= 1'b0;
      good_q           <= 1'b0;
      bad_q            <= 1'b0;
      moveTick_o       <= 1'b0;
      goodColl_o       <= 1'b0;
      badColl_o        <= 1'b0;
      scoreClr_o       <= 1'b0;
      isGameComplete_o <= 1'b0;
      isWin_o          <= 1'b0;
    end else begin
      state            <= state_n;
      level            <= level_n;
      eaten            <= eaten_n;
      apl_cnt          <= apl_cnt_n;
      cnt              <= cnt_n;
      start_q          <= start_i;
      pause_q          <= pause_i;
      good_q           <= goodColl_i;
      bad_q            <= badColl_i;
      moveTick_o       <= tick_n;
      goodColl_o       <= good_n;
      badColl_o        <= bad_n;
      scoreClr_o       <= clr_n;
      isGameComplete_o <= (state_n == OVER);
      isWin_o          <= win_n;
    end
  end

  assign state_o = state;
  assign level_o = level;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: dut_a wins at 5 apples, dut_b at 20 so the
// level/speed floor can be reached while both share one stimulus stream.
module tb_snake_game_ctrl;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, good = 1'b0, bad = 1'b0;
  logic       tick_a, good_a, bad_a, clr_a, done_a, win_a;
  logic       tick_b, good_b, bad_b, clr_b, done_b, win_b;
  logic [1:0] state_a, state_b;
  logic [3:0] level_a, level_b;

  int checks = 0;
  int errors = 0;

  always #5 tb_clk = ~tb_clk;

  snake_game_ctrl #(.TICK_INIT(8), .TICK_MIN(2), .TICK_STEP(2), .APPLES_PER_LEVEL(2),
                    .MAX_SCORE(5), .LEVEL_MAX(15)) u_dut_a (
    .clk(tb_clk), .nRst(rst), .start_i(start), .pause_i(pause),
    .goodColl_i(good), .badColl_i(bad), .moveTick_o(tick_a), .goodColl_o(good_a),
    .badColl_o(bad_a), .scoreClr_o(clr_a), .isGameComplete_o(done_a), .isWin_o(win_a),
    .state_o(state_a), .level_o(level_a));

  snake_game_ctrl #(.TICK_INIT(8), .TICK_MIN(2), .TICK_STEP(2), .APPLES_PER_LEVEL(2),
                    .MAX_SCORE(20), .LEVEL_MAX(15)) u_dut_b (
    .clk(tb_clk), .nRst(rst), .start_i(start), .pause_i(pause),
    .goodColl_i(good), .badColl_i(bad), .moveTick_o(tick_b), .goodColl_o(good_b),
    .badColl_o(bad_b), .scoreClr_o(clr_b), .isGameComplete_o(done_b), .isWin_o(win_b),
    .state_o(state_b), .level_o(level_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic pulse_good();
    good = 1'b1;
    step();
    good = 1'b0;
  endtask

  // Clocks until the selected DUT shows a move tick, bounded at 100.
  task automatic count_to_tick(input int which, output int n);
    logic tk;
    n = 0;
    do begin
      step();
      n++;
      tk = (which == 0) ? tick_a : tick_b;
    end while (!tk && n < 100);
  endtask

  initial begin
    int n, clr_cnt, tk_cnt, first, bad_seen;

    // Reset and IDLE
    step(); step();
    check("rst_state", state_a, 0);
    check("rst_done", done_a, 0);
    rst = 1'b0;
    step();
    pulse_good();
    check("idle_good", good_a, 0);
    bad = 1'b1; step(); bad = 1'b0;
    check("idle_bad", bad_a, 0);
    pause = 1'b1; step(); pause = 1'b0;
    check("idle_state", state_a, 0);

    // Start held for 20 clocks: one clear, ticks every 8
    start = 1'b1;
    step();
    check("start_state", state_a, 1);
    check("start_clr", clr_a, 1);
    clr_cnt = 0; tk_cnt = 0; first = 0;
    for (int i = 1; i <= 19; i++) begin
      step();
      if (clr_a) clr_cnt++;
      if (tick_a) begin
        tk_cnt++;
        if (tk_cnt == 1) first = i;
      end
    end
    start = 1'b0;
    check("held_clr", clr_cnt, 0);
    check("tick_cnt", tk_cnt, 2);
    check("first_tick", first, 8);
    count_to_tick(0, n);
    check("tick_gap8", n, 5);

    // Level-up after two apples
    pulse_good();
    check("apple1", good_a, 1);
    check("lvl_after1", level_a, 0);
    step();
    pulse_good();
    check("apple2", good_a, 1);
    check("lvl_after2", level_a, 1);
    count_to_tick(0, n);
    count_to_tick(0, n);
    check("tick_gap6", n, 6);

    // Pause with counter at 5, 30 frozen clocks, resume
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("pause_state", state_a, 2);
    clr_cnt = 0; tk_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      good = i[0];
      step();
      if (good_a) clr_cnt++;
      if (tick_a) tk_cnt++;
    end
    good = 1'b0;
    check("pause_goods", clr_cnt, 0);
    check("pause_ticks", tk_cnt, 0);
    check("pause_hold", state_a, 2);
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("resume_state", state_a, 1);
    check("resume_clr", clr_a, 0);
    count_to_tick(0, n);
    check("resume_tick", n, 5);

    // Simultaneous good and bad: bad wins
    good = 1'b1; bad = 1'b1;
    step();
    good = 1'b0; bad = 1'b0;
    check("prio_bad", bad_a, 1);
    check("prio_good", good_a, 0);
    check("prio_state", state_a, 3);
    check("prio_done", done_a, 1);
    check("prio_win", win_a, 0);
    step();
    check("bad_one_cycle", bad_a, 0);
    check("over_done_held", done_a, 1);

    // Restart, then win dut_a on the fifth apple
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_state", state_a, 1);
    check("restart_clr", clr_a, 1);
    check("restart_lvl", level_b, 0);
    check("restart_done", done_a, 0);
    for (int k = 1; k <= 5; k++) begin
      pulse_good();
      check($sformatf("win_apple%0d", k), good_a, 1);
      step();
    end
    check("win_state", state_a, 3);
    check("win_flag", win_a, 1);
    check("win_done", done_a, 1);
    check("win_lvl", level_a, 2);
    check("b_state", state_b, 1);
    check("b_lvl5", level_b, 2);

    // dut_b continues to 8 apples: level 4, period floored at 2
    bad_seen = 0;
    for (int k = 0; k < 3; k++) begin
      pulse_good();
      if (good_a) bad_seen++;
      step();
    end
    check("over_ignores_good", bad_seen, 0);
    check("over_win_held", win_a, 1);
    check("b_lvl8", level_b, 4);
    count_to_tick(1, n);
    count_to_tick(1, n);
    check("tick_gap2", n, 2);

    // Restart dut_a from OVER; dut_b ignores start while running
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs2_state", state_a, 1);
    check("rs2_clr", clr_a, 1);
    check("rs2_lvl", level_a, 0);
    check("rs2_done", done_a, 0);
    check("rs2_win", win_a, 0);
    check("b_no_clr", clr_b, 0);

    // Asynchronous reset mid-clock
    step();
    #3 rst = 1'b1;
    #1;
    check("arst_state_a", state_a, 0);
    check("arst_state_b", state_b, 0);
    check("arst_lvl_b", level_b, 0);
    check("arst_bad_b", bad_b, 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_state", state_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
